// File: rtl/fetch_pc_unit.sv
// PC and instruction register stage ahead of the control unit.
// Fetches instruction words over a req/ack handshake and applies PC updates selected by PS.
module fetch_pc_unit #(
   parameter int                 ADDR_W   = 64,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              IL,
   input  logic              EN_PC,
   input  logic [1:0]        PS,
   input  logic [63:0]       K,
   input  logic [63:0]       reg_in,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic [31:0]       IR,
   output logic [ADDR_W-1:0] PC,
   output logic              ir_valid,
   output logic              busy,
   output logic              align_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                req_q, req_d;
   logic [31:0]         ir_q, ir_d;
   logic                irv_q, irv_d;
   logic                aerr_q, aerr_d;

   // One-deep slot holding a PC update that arrived while a fetch was outstanding.
   logic                pend_vld_q, pend_vld_d;
   logic [1:0]          pend_ps_q, pend_ps_d;
   logic [63:0]         pend_k_q, pend_k_d;
   logic [63:0]         pend_rin_q, pend_rin_d;

   logic                upd_en;
   logic [1:0]          upd_ps;
   logic [63:0]         upd_k;
   logic [63:0]         upd_rin;
   logic [63:0]         upd_koff;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      req_d      = req_q;
      ir_d       = ir_q;
      irv_d      = irv_q;
      aerr_d     = aerr_q;
      pend_vld_d = pend_vld_q;
      pend_ps_d  = pend_ps_q;
      pend_k_d   = pend_k_q;
      pend_rin_d = pend_rin_q;
      upd_en     = 1'b0;
      upd_ps     = PS;
      upd_k      = K;
      upd_rin    = reg_in;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            // Fetch address uses the pre-update PC even if EN_PC fires this cycle.
            if (IL) begin
               state_d = S_WAIT;
               addr_d  = pc_q;
               req_d   = 1'b1;
               irv_d   = 1'b0;
            end
            upd_en = EN_PC;
         end
         S_WAIT: begin
            if (EN_PC) begin
               pend_vld_d = 1'b1;
               pend_ps_d  = PS;
               pend_k_d   = K;
               pend_rin_d = reg_in;
            end
            if (imem_ack) begin
               state_d    = S_DONE;
               ir_d       = imem_data;
               irv_d      = 1'b1;
               req_d      = 1'b0;
               pend_vld_d = 1'b0;
               // An EN_PC on the ack edge itself is the latest update and wins.
               if (EN_PC) begin
                  upd_en = 1'b1;
               end else if (pend_vld_q) begin
                  upd_en  = 1'b1;
                  upd_ps  = pend_ps_q;
                  upd_k   = pend_k_q;
                  upd_rin = pend_rin_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      upd_koff = upd_k << 2;
      if (upd_en) begin
         case (upd_ps)
            2'b01:   pc_d = pc_q + ADDR_W'(4);
            2'b10:   pc_d = pc_q + upd_koff[ADDR_W-1:0];
            2'b11: begin
               pc_d = {upd_rin[ADDR_W-1:2], 2'b00};
               if (upd_rin[1:0] != 2'b00) aerr_d = 1'b1;
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         ir_q       <= '0;
         irv_q      <= 1'b0;
         aerr_q     <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_ps_q  <= '0;
         pend_k_q   <= '0;
         pend_rin_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         ir_q       <= ir_d;
         irv_q      <= irv_d;
         aerr_q     <= aerr_d;
         pend_vld_q <= pend_vld_d;
         pend_ps_q  <= pend_ps_d;
         pend_k_q   <= pend_k_d;
         pend_rin_q <= pend_rin_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign IR        = ir_q;
   assign PC        = pc_q;
   assign ir_valid  = irv_q;
   assign busy      = (state_q == S_WAIT);
   assign align_err = aerr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit; expected values are hand-computed constants.
module tb_fetch_pc_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        IL, EN_PC, imem_ack;
   logic [1:0]  PS;
   logic [63:0] K, reg_in;
   logic [31:0] imem_data;
   logic        imem_req, ir_valid, busy, align_err;
   logic [63:0] imem_addr, PC;
   logic [31:0] IR;

   int n_vec = 0;
   int n_err = 0;

   fetch_pc_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
      .clock(clock), .reset(reset), .IL(IL), .EN_PC(EN_PC), .PS(PS), .K(K),
      .reg_in(reg_in), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .IR(IR), .PC(PC),
      .ir_valid(ir_valid), .busy(busy), .align_err(align_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pc_op(input logic [1:0] ps, input logic [63:0] k, input logic [63:0] rin);
      EN_PC = 1'b1; PS = ps; K = k; reg_in = rin;
      tick();
      EN_PC = 1'b0;
   endtask

   initial begin
      int req_cycles;
      reset = 1'b0; IL = 1'b0; EN_PC = 1'b0; PS = 2'b00; K = '0; reg_in = '0;
      imem_ack = 1'b0; imem_data = '0;
      tick(); tick();
      chk("rst_pc", PC, 64'h0);
      chk("rst_ir", 64'(IR), 64'h0);
      chk("rst_irv", 64'(ir_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_req", 64'(imem_req), 64'h0);
      chk("rst_aerr", 64'(align_err), 64'h0);
      reset = 1'b1;
      tick();

      // Basic fetch, ack in the third WAIT cycle.
      IL = 1'b1; tick(); IL = 1'b0;
      req_cycles = 0;
      for (int c = 0; c < 3; c++) begin
         if (imem_req) req_cycles++;
         chk("f1_addr", imem_addr, 64'h0);
         chk("f1_busy", 64'(busy), 64'h1);
         if (c == 2) begin imem_ack = 1'b1; imem_data = 32'h8B02_0020; end
         tick();
      end
      imem_ack = 1'b0;
      chk("f1_reqcyc", 64'(req_cycles), 64'd3);
      chk("f1_ir", 64'(IR), 64'h8B02_0020);
      chk("f1_irv", 64'(ir_valid), 64'h1);
      chk("f1_done_busy", 64'(busy), 64'h0);
      chk("f1_done_req", 64'(imem_req), 64'h0);
      tick();

      // Branch arithmetic.
      pc_op(2'b11, 64'h0, 64'h100);
      chk("ld_100", PC, 64'h100);
      chk("ld_aerr", 64'(align_err), 64'h0);
      pc_op(2'b10, -64'sd2, 64'h0);
      chk("br_neg", PC, 64'hF8);
      pc_op(2'b01, 64'h0, 64'h0);
      chk("inc", PC, 64'hFC);
      pc_op(2'b00, 64'h0, 64'h0);
      chk("hold", PC, 64'hFC);

      // Wrap-around and misaligned load.
      pc_op(2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("ld_top", PC, 64'hFFFF_FFFF_FFFF_FFFC);
      pc_op(2'b01, 64'h0, 64'h0);
      chk("wrap", PC, 64'h0);
      pc_op(2'b11, 64'h0, 64'h2003);
      chk("ld_mis_pc", PC, 64'h2000);
      chk("ld_mis_aerr", 64'(align_err), 64'h1);
      for (int i = 0; i < 10; i++) tick();
      chk("aerr_sticky", 64'(align_err), 64'h1);

      // Two updates queued during one WAIT: the last wins.
      pc_op(2'b11, 64'h0, 64'h40);
      IL = 1'b1; tick(); IL = 1'b0;
      chk("pend_addr0", imem_addr, 64'h40);
      pc_op(2'b01, 64'h0, 64'h0);
      chk("pend_addr1", imem_addr, 64'h40);
      chk("pend_pc1", PC, 64'h40);
      pc_op(2'b10, 64'd4, 64'h0);
      chk("pend_addr2", imem_addr, 64'h40);
      chk("pend_pc2", PC, 64'h40);
      imem_ack = 1'b1; imem_data = 32'hA5A5_0001; tick(); imem_ack = 1'b0;
      chk("pend_pc_ack", PC, 64'h50);
      chk("pend_ir", 64'(IR), 64'hA5A5_0001);
      tick();

      // IL and EN_PC together in IDLE: fetch from the old PC.
      IL = 1'b1; pc_op(2'b01, 64'h0, 64'h0); IL = 1'b0;
      chk("ilen_addr", imem_addr, 64'h50);
      chk("ilen_pc", PC, 64'h54);

      // Reset while waiting.
      reset = 1'b0; tick(); reset = 1'b1;
      chk("rw_req", 64'(imem_req), 64'h0);
      chk("rw_busy", 64'(busy), 64'h0);
      chk("rw_pc", PC, 64'h0);
      chk("rw_irv", 64'(ir_valid), 64'h0);
      chk("rw_aerr", 64'(align_err), 64'h0);
      imem_ack = 1'b1; imem_data = 32'hCAFE_F00D; tick(); imem_ack = 1'b0;
      chk("rw_late_ir", 64'(IR), 64'h0);

      // Stray ack in IDLE, and IL during WAIT is dropped.
      imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
      chk("stray_ir", 64'(IR), 64'h0);
      chk("stray_irv", 64'(ir_valid), 64'h0);
      IL = 1'b1; tick(); IL = 1'b0;
      tick();
      IL = 1'b1; tick(); IL = 1'b0;
      chk("ilw_req", 64'(imem_req), 64'h1);
      imem_ack = 1'b1; imem_data = 32'h1234_5678; tick(); imem_ack = 1'b0;
      chk("ilw_ir", 64'(IR), 64'h1234_5678);
      chk("ilw_irv", 64'(ir_valid), 64'h1);
      tick();
      chk("ilw_idle_req", 64'(imem_req), 64'h0);
      chk("ilw_idle_busy", 64'(busy), 64'h0);
      tick();
      chk("ilw_no_refetch", 64'(imem_req), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program counter and instruction register stage; sits directly upstream of the control unit.
- Holds the PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Latches each fetched word into IR, which drives the control unit's IR input.
- Applies PC updates from the control unit's PS/EN_PC/K fields and the register-file bus.

Parameters:
- ADDR_W, 64, PC and memory address width
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- IL  in  1  fetch request strobe from control unit (single-cycle pulse)
- EN_PC  in  1  PC update strobe
- PS  in  2  PC update select: 00 hold, 01 PC+4, 10 PC+(K<<2), 11 load reg_in
- K  in  64  signed word offset for PS=10
- reg_in  in  64  register-file A bus, used for PS=11
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  memory data valid (one-cycle pulse)
- imem_data  in  32  instruction word
- IR  out  32  instruction register
- PC  out  ADDR_W  current program counter
- ir_valid  out  1  IR holds a word fetched since the last IL
- busy  out  1  fetch in progress
- align_err  out  1  sticky: a misaligned reg_in was loaded

Behaviour:
- Reset, when reset=0 at a clock edge:
  - PC=RESET_PC; IR=0; ir_valid=0; busy=0; imem_req=0; align_err=0.
  - Any pending update is cleared; the FSM goes to IDLE.
  - Reset overrides every other input on that edge, including mid-fetch.
- FSM states:
  - IDLE: IL=1 -> WAIT. imem_addr latched from PC; imem_req=1 and busy=1 from the next cycle; ir_valid cleared.
  - WAIT: imem_req held at 1 and imem_addr held stable until imem_ack=1. On ack: IR<=imem_data, ir_valid<=1, imem_req<=0, -> DONE.
  - DONE: one cycle with busy=0, then -> IDLE. IL=1 in DONE starts a new fetch, as in IDLE.
- Latency: with an ack in the first WAIT cycle, IR is valid 2 cycles after IL.
- IL while in WAIT is ignored; no queuing.
- imem_ack outside WAIT is ignored; IR is unchanged.
- PC update when EN_PC=1, outside WAIT:
  - PS=00: PC unchanged.
  - PS=01: PC <= PC+4.
  - PS=10: PC <= PC + (K<<2).
  - PS=11: PC <= {reg_in[ADDR_W-1:2],2'b00}; align_err set if reg_in[1:0]!=0.
- PC update arithmetic:
  - Modulo 2^ADDR_W; wrap-around is silent, e.g. PC=FFFF_FFFF_FFFF_FFFC with PS=01 gives 0.
  - K is two's complement; a negative offset branches backwards.
  - Bits of K shifted out above ADDR_W are discarded.
- EN_PC during WAIT:
  - PS, K and reg_in are captured into a one-deep pending slot; PC and imem_addr are unchanged.
  - The pending update is applied on the edge that ends WAIT (the ack edge).
  - A second EN_PC during the same WAIT overwrites the slot; the last one wins.
- EN_PC and IL in the same IDLE cycle:
  - The fetch uses the old PC.
  - PC updates on the same edge.
- align_err clears only on reset.
- PC, IR and ir_valid are registered; no output depends combinationally on an input.

Test Plan:
- Reset then IL, memory acks after 3 WAIT cycles with 0x8B020020 -> imem_req high 3 cycles, imem_addr=0 throughout; IR=0x8B020020 and ir_valid=1 on the ack edge; busy low in DONE.
- PC=0x100, EN_PC with PS=10 and K=-2 -> PC=0xF8; then PS=01 -> PC=0xFC; then PS=00 -> PC stays 0xFC.
- PC=0xFFFFFFFFFFFFFFFC, PS=01 -> PC=0. PS=11 with reg_in=0x2003 -> PC=0x2000, align_err=1 and still 1 after ten idle cycles.
- EN_PC PS=01 then EN_PC PS=10 (K=4) during one WAIT at PC=0x40 -> imem_addr stays 0x40; after the ack PC=0x50 (the PS=01 update is discarded).
- reset asserted in WAIT -> next cycle imem_req=0, busy=0, PC=RESET_PC, ir_valid=0; a late imem_ack leaves IR=0.
- Stray imem_ack in IDLE with data 0xDEADBEEF, and IL pulsed during WAIT -> IR unchanged; only one fetch issued.
